// File: rtl/wrr_arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package wrr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } wrr_state_t;

  // Next index after idx, wrapping from cnt-1 back to 0.
  function automatic logic [31:0] wrap_inc(input logic [31:0] idx, input logic [31:0] cnt);
    return (idx == cnt - 32'd1) ? 32'd0 : idx + 32'd1;
  endfunction

  // A zero weight still earns one grant per turn.
  function automatic logic [31:0] eff_weight(input logic [31:0] w);
    return (w == 32'd0) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/wrr_pick.sv
// Rotate-priority encoder: first set request scanning from ptr upward, wrapping.
// Latency: purely combinational; backpressure: none, no state.
module wrr_pick #(
  parameter int REQCNT = 4
) (
  input  logic [REQCNT-1:0]         req,
  input  logic [$clog2(REQCNT)-1:0] ptr,
  output logic [$clog2(REQCNT)-1:0] idx,
  output logic                      any
);

  localparam int IW = $clog2(REQCNT);
  localparam logic [IW:0] NUM = (IW+1)'(REQCNT);

  logic [REQCNT-1:0] rot;
  logic [IW:0]       sum;

  // Duplicating the vector turns the wrap-around scan into a plain shift.
  assign rot = REQCNT'({req, req} >> ptr);

  always_comb begin
    sum = '0;
    any = 1'b0;
    // Scan downward so the lowest rotated position wins.
    for (int k = REQCNT - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, ptr} + (IW+1)'(k);
        any = 1'b1;
      end
    end
    if (sum >= NUM) begin
      sum = sum - NUM;
    end
    idx = sum[IW-1:0];
  end

endmodule

// File: rtl/wrr_arb_top.sv
// Weighted round-robin arbiter: each winner holds the grant for up to its weight in transfers.
// Latency: request to grant one cycle, no bubble between turns; backpressure: gnt_rdy_i low holds the grant.
module wrr_arb_top
  import wrr_arb_pkg::*;
#(
  parameter int REQCNT = 4,
  parameter int WGTW   = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [REQCNT-1:0]            req_i,
  input  logic [REQCNT-1:0][WGTW-1:0]  weight_i,
  input  logic                         gnt_rdy_i,
  output logic [$clog2(REQCNT)-1:0]    req_num_o,
  output logic                         req_num_val_o,
  output logic                         burst_last_o
);

  localparam int IW = $clog2(REQCNT);

  wrr_state_t      state, state_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic [IW-1:0]   cur, cur_nxt;
  logic [WGTW-1:0] cred, cred_nxt;

  logic [IW-1:0]   ptr_after;
  logic [IW-1:0]   pick_ptr;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic [WGTW-1:0] cred_load;
  logic            in_grant;
  logic            xfer;
  logic            cur_req;
  logic            cred_one;
  logic            turn_end;

  assign in_grant  = (state == GRANT);
  assign xfer      = in_grant & gnt_rdy_i;
  assign cur_req   = req_i[cur];
  assign cred_one  = (cred == WGTW'(1));
  // Credit exhausted on a transfer, or the owner withdrew (with or without a transfer).
  assign turn_end  = in_grant & ((xfer & cred_one) | ~cur_req);
  assign ptr_after = IW'(wrap_inc(32'(cur), REQCNT));

  // Re-arbitrate against the advanced pointer at turn end so the outgoing owner ranks last.
  assign pick_ptr  = turn_end ? ptr_after : ptr;
  assign cred_load = WGTW'(eff_weight(32'(weight_i[pick_idx])));

  wrr_pick #(
    .REQCNT(REQCNT)
  ) u_pick (
    .req (req_i),
    .ptr (pick_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      ptr   <= '0;
      cur   <= '0;
      cred  <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cur   <= cur_nxt;
      cred  <= cred_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cur_nxt   = cur;
    cred_nxt  = cred;
    case (state)
      IDLE: begin
        if (pick_any) begin
          cur_nxt   = pick_idx;
          cred_nxt  = cred_load;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (turn_end) begin
          ptr_nxt = ptr_after;
          if (pick_any) begin
            cur_nxt  = pick_idx;
            cred_nxt = cred_load;
          end else begin
            state_nxt = IDLE;
          end
        end else if (xfer && cred > WGTW'(1)) begin
          cred_nxt = cred - WGTW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req_num_val_o = in_grant;
  assign req_num_o     = cur;
  assign burst_last_o  = in_grant & cred_one;

endmodule

// File: tb/tb_wrr_arb_top.sv
// Directed bench for wrr_arb_top with REQCNT=4, WGTW=4; inputs change and outputs are sampled on the falling edge.
module tb_wrr_arb_top;

  logic             clk;
  logic             rst;
  logic [3:0]       req;
  logic [3:0][3:0]  weight;
  logic             rdy;
  logic [1:0]       num;
  logic             val;
  logic             last;

  int vec_cnt = 0;
  int err_cnt = 0;

  wrr_arb_top #(
    .REQCNT(4),
    .WGTW  (4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_i         (req),
    .weight_i      (weight),
    .gnt_rdy_i     (rdy),
    .req_num_o     (num),
    .req_num_val_o (val),
    .burst_last_o  (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse reset for one cycle; callers set req/weight/rdy beforehand.
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b0000;
    rdy = 1'b1;
    weight = {4'd4, 4'd4, 4'd4, 4'd4};
    repeat (2) @(negedge clk);
    vec_cnt++;
    if (val !== 1'b0 || num !== 2'd0 || last !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_hold: val=%b num=%0d last=%b, want 0 0 0", val, num, last);
    end
    rst = 1'b0;
    req = 4'b1111;
    @(negedge clk);
    vec_cnt++;
    if (val !== 1'b1 || num !== 2'd0 || last !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_first: val=%b num=%0d last=%b, want 1 0 0", val, num, last);
    end
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    vec_cnt++;
    if (val !== 1'b0 || num !== 2'd0 || last !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_async: val=%b num=%0d last=%b, want 0 0 0", val, num, last);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (val !== 1'b1 || num !== 2'd0) begin
      err_cnt++;
      $display("FAIL reset_regrant: val=%b num=%0d, want 1 0", val, num);
    end
  endtask

  task automatic test_weighted();
    logic [1:0] en [13];
    logic       el [13];
    en = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd1, 2'd1};
    el = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    req = 4'b1111;
    rdy = 1'b1;
    weight = {4'd4, 4'd3, 4'd2, 4'd1};
    apply_reset();
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      vec_cnt++;
      if (val !== 1'b1 || num !== en[c] || last !== el[c]) begin
        err_cnt++;
        $display("FAIL weighted[%0d]: val=%b num=%0d last=%b, want 1 %0d %b", c, val, num, last, en[c], el[c]);
      end
    end
  endtask

  task automatic test_zero_weight();
    logic [1:0] en [5];
    en = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    req = 4'b1111;
    rdy = 1'b1;
    weight = {4'd0, 4'd0, 4'd0, 4'd0};
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vec_cnt++;
      if (val !== 1'b1 || num !== en[c] || last !== 1'b1) begin
        err_cnt++;
        $display("FAIL zero_wgt[%0d]: val=%b num=%0d last=%b, want 1 %0d 1", c, val, num, last, en[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] en [12];
    logic       el [12];
    int         ch2_xfers;
    en = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
    el = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    ch2_xfers = 0;
    req = 4'b1111;
    rdy = 1'b1;
    weight = {4'd4, 4'd3, 4'd2, 4'd1};
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      vec_cnt++;
      if (val !== 1'b1 || num !== en[c] || last !== el[c]) begin
        err_cnt++;
        $display("FAIL backpress[%0d]: val=%b num=%0d last=%b, want 1 %0d %b", c, val, num, last, en[c], el[c]);
      end
      // Stall during ch2's second grant (cycles 5..7, zero-based 4..6).
      rdy = (c >= 4 && c <= 6) ? 1'b0 : 1'b1;
      if (val === 1'b1 && num === 2'd2 && rdy === 1'b1) ch2_xfers++;
    end
    vec_cnt++;
    if (ch2_xfers != 3) begin
      err_cnt++;
      $display("FAIL backpress_count: ch2 transfers=%0d, want 3", ch2_xfers);
    end
  endtask

  task automatic test_cancel();
    req = 4'b0110;
    rdy = 1'b1;
    weight = {4'd1, 4'd1, 4'd4, 4'd1};
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vec_cnt++;
      if (val !== 1'b1 || num !== 2'd1 || last !== 1'b0) begin
        err_cnt++;
        $display("FAIL cancel_pre[%0d]: val=%b num=%0d last=%b, want 1 1 0", c, val, num, last);
      end
    end
    // Two transfers completed; ch1 withdraws while its third grant is shown.
    req = 4'b0100;
    @(negedge clk);
    vec_cnt++;
    if (val !== 1'b1 || num !== 2'd2 || last !== 1'b1) begin
      err_cnt++;
      $display("FAIL cancel_next: val=%b num=%0d last=%b, want 1 2 1", val, num, last);
    end
    vec_cnt++;
    if (dut.ptr !== 2'd2) begin
      err_cnt++;
      $display("FAIL cancel_ptr: ptr=%0d, want 2", dut.ptr);
    end
  endtask

  task automatic test_single();
    logic el [4];
    el = '{1'b0, 1'b1, 1'b0, 1'b1};
    req = 4'b1000;
    rdy = 1'b1;
    weight = {4'd2, 4'd1, 4'd1, 4'd1};
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vec_cnt++;
      if (val !== 1'b1 || num !== 2'd3 || last !== el[c]) begin
        err_cnt++;
        $display("FAIL single[%0d]: val=%b num=%0d last=%b, want 1 3 %b", c, val, num, last, el[c]);
      end
    end
    req = 4'b0000;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if (val !== 1'b0) begin
      err_cnt++;
      $display("FAIL idle_return: val=%b, want 0", val);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    rdy = 1'b0;
    weight = '0;
    test_reset();
    test_weighted();
    test_zero_weight();
    test_backpressure();
    test_cancel();
    test_single();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
